// File: rtl/aemb2_iwb_rsp.sv
// Instruction-side Wishbone responder: RAM-backed fetch port with programmable
// wait states and an always-granted loader write port.
module aemb2_iwb_rsp #(
    parameter int unsigned IWB = 32,
    parameter int unsigned AW  = 10,
    parameter int unsigned LAT = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            iwb_stb_i,
    input  logic [IWB-3:0]  iwb_adr_i,
    output logic [31:0]     iwb_dat_o,
    output logic            iwb_ack_o,
    input  logic            ld_we_i,
    input  logic [AW-1:0]   ld_adr_i,
    input  logic [31:0]     ld_dat_i,
    output logic            busy_o
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [2:0]  CNT_INIT = (LAT == 0) ? 3'd0 : 3'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    logic [31:0]   ram [DEPTH];

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   dat_q, dat_d;

    logic          rd_en;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    // Address bits above the RAM index alias and are deliberately ignored.
    logic unused_adr_hi;
    assign unused_adr_hi = ^iwb_adr_i[IWB-3:AW];

    // Loader write port; never stalled by fetch activity.
    always_ff @(posedge clk_i) begin
        if (ld_we_i) begin
            ram[ld_adr_i] <= ld_dat_i;
        end
    end

    // Fetch FSM next-state, wait counter and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        rd_en   = 1'b0;
        rd_idx  = idx_q;

        case (state_q)
            S_IDLE: begin
                if (iwb_stb_i && !ld_we_i) begin
                    idx_d  = iwb_adr_i[AW-1:0];
                    rd_idx = iwb_adr_i[AW-1:0];
                    if (LAT == 0) begin
                        state_d = S_ACK;
                        rd_en   = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_ACK;
                    rd_en   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The word is read on the edge entering ACK so that loader writes made
        // while waiting are seen; a write landing on that same edge is forwarded.
        if (ld_we_i && (ld_adr_i == rd_idx)) begin
            rd_word = ld_dat_i;
        end else begin
            rd_word = ram[rd_idx];
        end
        if (rd_en) begin
            dat_d = rd_word;
        end
    end

    // State, counter, latched index and output data registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
        end
    end

    assign iwb_dat_o = dat_q;
    assign iwb_ack_o = (state_q == S_ACK) && iwb_stb_i;
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_aemb2_iwb_rsp.sv
// Scoreboard bench for aemb2_iwb_rsp: one instance with LAT=0, one with LAT=3,
// sharing clock, reset and loader port.
module tb_aemb2_iwb_rsp;

    typedef struct packed {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb  [2];
    logic [29:0] adr  [2];
    logic [31:0] dat  [2];
    logic        ack  [2];
    logic        busy [2];
    logic        ld_we;
    logic [9:0]  ld_adr;
    logic [31:0] ld_dat;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e;
    int   bc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aemb2_iwb_rsp #(.IWB(32), .AW(10), .LAT(0)) u_lat0 (
        .clk_i(clk), .rst_i(rst), .iwb_stb_i(stb[0]), .iwb_adr_i(adr[0]),
        .iwb_dat_o(dat[0]), .iwb_ack_o(ack[0]), .ld_we_i(ld_we),
        .ld_adr_i(ld_adr), .ld_dat_i(ld_dat), .busy_o(busy[0])
    );

    aemb2_iwb_rsp #(.IWB(32), .AW(10), .LAT(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .iwb_stb_i(stb[1]), .iwb_adr_i(adr[1]),
        .iwb_dat_o(dat[1]), .iwb_ack_o(ack[1]), .ld_we_i(ld_we),
        .ld_adr_i(ld_adr), .ld_dat_i(ld_dat), .busy_o(busy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_adr = a; ld_dat = d;
        tick();
        ld_we = 1'b0;
    endtask

    // Issue a fetch on instance d, push the expected word and ack cycle, hold stb
    // until ack. Optional same-cycle loader collision or a write wr_at cycles later.
    task automatic fetch(input int d, input logic [29:0] a, input logic [31:0] exp,
                         input int lat, input bit ld_same, input int wr_at,
                         input logic [9:0] wadr, input logic [31:0] wdat,
                         output int bcnt);
        exp_t x;
        bit   got;
        bcnt = 0;
        got  = 1'b0;
        if (ld_same) begin
            ld_we = 1'b1; ld_adr = wadr; ld_dat = wdat;
        end
        stb[d] = 1'b1;
        adr[d] = a;
        x.dat = exp;
        x.cyc = cyc + 1 + lat + (ld_same ? 1 : 0);
        if (d == 0) q0.push_back(x); else q1.push_back(x);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy[d] === 1'b1) bcnt++;
            if (ack[d] === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
            if (i == wr_at) begin
                ld_we = 1'b1; ld_adr = wadr; ld_dat = wdat;
            end else begin
                ld_we = 1'b0;
            end
        end
        if (!got) chk($sformatf("ack_timeout_d%0d", d), 32'd0, 32'd1);
        tick();
        stb[d] = 1'b0;
        ld_we  = 1'b0;
    endtask

    // Monitor: every ack pops the matching expectation and checks data and timing.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d] === 1'b1) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk($sformatf("unexpected_ack_d%0d", d), 32'd1, 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("ack_dat_d%0d", d), dat[d], e.dat);
                    chk($sformatf("ack_cyc_d%0d", d), cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ld_we = 1'b0; ld_adr = '0; ld_dat = '0;
        for (int d = 0; d < 2; d++) begin
            stb[d] = 1'b0; adr[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ack_d%0d", d), 32'(ack[d]), 32'd0);
            chk($sformatf("rst_dat_d%0d", d), dat[d], 32'd0);
            chk($sformatf("rst_busy_d%0d", d), 32'(busy[d]), 32'd0);
        end
        tick();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) load(10'(i), 32'hB000_0000 + 32'(i));
        load(10'd1023, 32'hDEAD_BEEF);

        fetch(0, 30'd5, 32'hB000_0005, 0, 1'b0, -1, '0, '0, bc);
        chk("busy_cnt_lat0", 32'(bc), 32'd1);
        fetch(1, 30'd2, 32'hB000_0002, 3, 1'b0, -1, '0, '0, bc);
        chk("busy_cnt_lat3", 32'(bc), 32'd4);

        fetch(0, 30'h405, 32'hB000_0005, 0, 1'b0, -1, '0, '0, bc);
        fetch(0, 30'h3FF, 32'hDEAD_BEEF, 0, 1'b0, -1, '0, '0, bc);
        fetch(1, 30'h7FF, 32'hDEAD_BEEF, 3, 1'b0, -1, '0, '0, bc);

        fetch(0, 30'd7, 32'hCAFE_0007, 0, 1'b1, -1, 10'd7, 32'hCAFE_0007, bc);
        fetch(1, 30'd7, 32'hCAFE_1007, 3, 1'b1, -1, 10'd7, 32'hCAFE_1007, bc);
        chk("busy_cnt_defer", 32'(bc), 32'd4);

        fetch(1, 30'd9,  32'h9999_0009, 3, 1'b0, 1, 10'd9,  32'h9999_0009, bc);
        fetch(1, 30'd10, 32'hAAAA_000A, 3, 1'b0, 2, 10'd10, 32'hAAAA_000A, bc);
        fetch(1, 30'd11, 32'hB000_000B, 3, 1'b0, 1, 10'd12, 32'h1212_1212, bc);
        fetch(0, 30'd12, 32'h1212_1212, 0, 1'b0, -1, '0, '0, bc);

        stb[1] = 1'b1; adr[1] = 30'd3;
        tick();
        stb[1] = 1'b0;
        bc = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy[1] === 1'b1) bc++;
        end
        chk("drop_busy_cnt", 32'(bc), 32'd4);
        tick();
        fetch(1, 30'd3, 32'hB000_0003, 3, 1'b0, -1, '0, '0, bc);
        chk("after_drop_busy", 32'(bc), 32'd4);

        stb[1] = 1'b1; adr[1] = 30'd4;
        tick();
        tick();
        rst = 1'b1;
        stb[1] = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_ack", 32'(ack[1]), 32'd0);
        chk("midrst_dat", dat[1], 32'd0);
        chk("midrst_busy", 32'(busy[1]), 32'd0);
        chk("midrst_dat_d0", dat[0], 32'd0);
        tick();
        rst = 1'b0;
        fetch(1, 30'd4, 32'hB000_0004, 3, 1'b0, -1, '0, '0, bc);
        fetch(0, 30'd6, 32'hB000_0006, 0, 1'b0, -1, '0, '0, bc);

        repeat (4) tick();
        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
